// File: rtl/sw_stim_gen.sv
// Programmable switch-stimulus generator: constant, increment, walking-one
// and Galois-LFSR vector sequences, each held for a programmable cycle count.
module sw_stim_gen #(
    parameter int unsigned            DATA_W = 32,
    parameter int unsigned            HOLD_W = 16,
    parameter int unsigned            CNT_W  = 16,
    parameter logic [DATA_W-1:0]      SEED   = 32'hACE1_2025,
    parameter logic [DATA_W-1:0]      TAPS   = 32'h8020_0003
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_init,
    input  logic [HOLD_W-1:0] i_hold,
    input  logic [CNT_W-1:0]  i_count,
    output logic [DATA_W-1:0] o_sw_data,
    output logic              o_update,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_vec_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] lhold_q, lhold_d;
    logic [CNT_W-1:0]  lcount_q, lcount_d;
    logic [1:0]        mode_q, mode_d;
    logic              upd_q, upd_d;

    logic [DATA_W-1:0] first_vec;
    logic [DATA_W-1:0] next_vec;
    logic              last_vec;

    always_comb begin
        first_vec = i_init;
        unique case (i_mode)
            2'd2:    first_vec = DATA_W'(1);
            2'd3:    first_vec = (i_init == '0) ? SEED : i_init;
            default: first_vec = i_init;
        endcase
    end

    always_comb begin
        next_vec = data_q;
        unique case (mode_q)
            2'd1:    next_vec = data_q + DATA_W'(1);
            2'd2:    next_vec = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
            2'd3:    next_vec = (data_q >> 1) ^ (data_q[0] ? TAPS : '0);
            default: next_vec = data_q;
        endcase
    end

    // A zero count means free-running, so it never terminates the run.
    assign last_vec = (lcount_q != '0) && (idx_q == lcount_q - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        lhold_d  = lhold_q;
        lcount_d = lcount_q;
        mode_d   = mode_q;
        upd_d    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d  = S_RUN;
                    mode_d   = i_mode;
                    lhold_d  = i_hold;
                    lcount_d = i_count;
                    hold_d   = i_hold;
                    data_d   = first_vec;
                    idx_d    = '0;
                    upd_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    data_d = next_vec;
                    idx_d  = idx_q + CNT_W'(1);
                    hold_d = lhold_q;
                    upd_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            lhold_q  <= '0;
            lcount_q <= '0;
            mode_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            lhold_q  <= lhold_d;
            lcount_q <= lcount_d;
            mode_q   <= mode_d;
            upd_q    <= upd_d;
        end
    end

    assign o_sw_data = data_q;
    assign o_update  = upd_q;
    assign o_busy    = (state_q == S_RUN);
    assign o_done    = (state_q == S_DONE);
    assign o_vec_idx = idx_q;

endmodule
